// File: rtl/id_stage_if.sv
// ID/EX channel: the held decoded entry presented to execute under a valid/ready handshake.
// The master (id_stage) drives the entry and valid; the slave (execute) drives ready.
interface id_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic [31:0] id_imm;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic        id_regwrite;
  logic        id_is_load;
  logic        id_illegal;

  modport master (
    output id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd,
           id_opcode, id_funct3, id_funct7b5, id_regwrite, id_is_load, id_illegal,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd,
           id_opcode, id_funct3, id_funct7b5, id_regwrite, id_is_load, id_illegal,
    output id_ready
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: regfile read addressing, operand capture, immediate/control decode,
// one held ID/EX entry, load-use hazard detection with LOAD_BUBBLES bubble cycles.
// Optional feature macro ID_WB_BYPASS_EN: when defined, a writeback to a used source in the
// accept cycle is bypassed into the operand; when undefined, such a conflict stalls fetch one cycle.
module id_stage #(
  parameter int XLEN         = 32,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            flush,
  id_stage_if.master      idx
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        legal, use_rs1, use_rs2, regwrite_d;
  logic [31:0] imm_d, rs1_val_d, rs2_val_d;
  logic        byp1, byp2, wb_stall, hazard, accept;
  logic [1:0]  cnt;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  // Opcode classification, source usage and sign-extended immediate.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    legal   = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    imm_d   = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        use_rs1 = 1'b0;
        imm_d   = {if_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        use_rs1 = 1'b0;
        imm_d   = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM: imm_d = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE: begin
        use_rs2 = 1'b1;
        imm_d   = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OP_BRANCH: begin
        use_rs2 = 1'b1;
        imm_d   = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OP_OP:   use_rs2 = 1'b1;
      default: legal   = 1'b0;
    endcase
  end

  assign regwrite_d = legal && (opcode != OP_BRANCH) && (opcode != OP_STORE);

`ifdef ID_WB_BYPASS_EN
  assign byp1     = use_rs1 && wb_regwrite && (wb_rd == rs1);
  assign byp2     = use_rs2 && wb_regwrite && (wb_rd == rs2);
  assign wb_stall = 1'b0;
`else
  assign byp1     = 1'b0;
  assign byp2     = 1'b0;
  assign wb_stall = wb_regwrite && (wb_rd != 5'd0) &&
                    ((use_rs1 && (wb_rd == rs1)) || (use_rs2 && (wb_rd == rs2)));
`endif

  // x0 always reads as zero; otherwise take the bypassed writeback or the regfile value.
  assign rs1_val_d = (rs1 == 5'd0) ? '0 : (byp1 ? wb_wdata : rf_rdata1);
  assign rs2_val_d = (rs2 == 5'd0) ? '0 : (byp2 ? wb_wdata : rf_rdata2);

  // Load-use: the held load's destination is a source of the presented instruction.
  assign hazard = idx.id_valid && idx.id_is_load && (idx.id_rd != 5'd0) &&
                  ((use_rs1 && (rs1 == idx.id_rd)) || (use_rs2 && (rs2 == idx.id_rd)));

  assign if_ready = !rst && !flush && (!idx.id_valid || idx.id_ready) &&
                    !hazard && (cnt == 2'd0) && !wb_stall;
  assign accept   = if_valid && if_ready;

  // ID/EX entry register and load-use bubble counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      idx.id_valid    <= 1'b0;
      idx.id_pc       <= '0;
      idx.id_rs1_val  <= '0;
      idx.id_rs2_val  <= '0;
      idx.id_imm      <= '0;
      idx.id_rd       <= '0;
      idx.id_opcode   <= '0;
      idx.id_funct3   <= '0;
      idx.id_funct7b5 <= 1'b0;
      idx.id_regwrite <= 1'b0;
      idx.id_is_load  <= 1'b0;
      idx.id_illegal  <= 1'b0;
      cnt             <= '0;
    end else if (flush) begin
      idx.id_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      if (accept) begin
        idx.id_valid    <= 1'b1;
        idx.id_pc       <= if_pc;
        idx.id_rs1_val  <= rs1_val_d;
        idx.id_rs2_val  <= rs2_val_d;
        idx.id_imm      <= imm_d;
        idx.id_rd       <= regwrite_d ? rd : 5'd0;
        idx.id_opcode   <= opcode;
        idx.id_funct3   <= if_instr[14:12];
        idx.id_funct7b5 <= if_instr[30];
        idx.id_regwrite <= regwrite_d;
        idx.id_is_load  <= (opcode == OP_LOAD);
        idx.id_illegal  <= !legal;
      end else if (idx.id_ready) begin
        idx.id_valid <= 1'b0;
      end
      if (idx.id_valid && idx.id_ready && hazard) cnt <= 2'(LOAD_BUBBLES);
      else if (cnt != 2'd0)                       cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode, writeback conflict, load-use bubble,
// stall/flush, branch immediate, illegal opcode and reset during a stall.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        flush;
  logic [31:0] rf [32];

  int tests = 0;
  int fails = 0;

  id_stage_if bus ();

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .rf_rs1     (rf_rs1),
    .rf_rs2     (rf_rs2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .wb_regwrite(wb_regwrite),
    .wb_rd      (wb_rd),
    .wb_wdata   (wb_wdata),
    .flush      (flush),
    .idx        (bus)
  );

  always #5 clk = ~clk;

  // Simple regfile model: combinational read, write on the clock edge.
  assign rf_rdata1 = rf[rf_rs1];
  assign rf_rdata2 = rf[rf_rs2];
  always @(posedge clk) if (wb_regwrite && wb_rd != 5'd0) rf[wb_rd] <= wb_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, checks follow a settle delay.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'h0000_0100;
    rf[5] = 32'h0000_0055;
    rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_wdata = '0; flush = 1'b0;
    bus.id_ready = 1'b0;

    // 1: reset for two cycles
    tick(); #2;
    check("rst1_if_ready", {31'b0, if_ready}, 32'd0);
    check("rst1_id_valid", {31'b0, bus.id_valid}, 32'd0);
    tick(); #2;
    check("rst2_if_ready", {31'b0, if_ready}, 32'd0);
    check("rst2_id_pc", bus.id_pc, 32'd0);
    tick(); rst = 1'b0; #2;
    check("post_rst_if_ready", {31'b0, if_ready}, 32'd1);
    check("post_rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("post_rst_id_imm", bus.id_imm, 32'd0);

    // 2: ADDI x1,x0,5
    if_valid = 1'b1; if_instr = 32'h0050_0093; if_pc = 32'h100; bus.id_ready = 1'b1;
    #2 check("addi_rf_rs1", {27'b0, rf_rs1}, 32'd0);
    tick(); if_valid = 1'b0; #2;
    check("addi_valid", {31'b0, bus.id_valid}, 32'd1);
    check("addi_rd", {27'b0, bus.id_rd}, 32'd1);
    check("addi_imm", bus.id_imm, 32'd5);
    check("addi_rs1_val", bus.id_rs1_val, 32'd0);
    check("addi_regwrite", {31'b0, bus.id_regwrite}, 32'd1);
    check("addi_pc", bus.id_pc, 32'h100);
    check("addi_opcode", {25'b0, bus.id_opcode}, 32'h13);

    // 3: ADD x3,x2,x2 while writeback writes x2
    if_valid = 1'b1; if_instr = 32'h0021_01B3; if_pc = 32'h104;
    wb_regwrite = 1'b1; wb_rd = 5'd2; wb_wdata = 32'hDEAD_BEEF;
`ifdef ID_WB_BYPASS_EN
    #2 check("wb_byp_if_ready", {31'b0, if_ready}, 32'd1);
    tick(); wb_regwrite = 1'b0; #2;
`else
    #2 check("wb_stall_if_ready", {31'b0, if_ready}, 32'd0);
    tick(); wb_regwrite = 1'b0; #2;
    check("wb_after_if_ready", {31'b0, if_ready}, 32'd1);
    check("wb_after_id_valid", {31'b0, bus.id_valid}, 32'd0);
    tick(); #2;
`endif
    check("add_valid", {31'b0, bus.id_valid}, 32'd1);
    check("add_rs1_val", bus.id_rs1_val, 32'hDEAD_BEEF);
    check("add_rs2_val", bus.id_rs2_val, 32'hDEAD_BEEF);
    check("add_rd", {27'b0, bus.id_rd}, 32'd3);
    check("add_pc", bus.id_pc, 32'h104);

    // 4: LW x5,0(x1) replaces the ADD on the same edge, then a dependent ADD
    if_instr = 32'h0000_A283; if_pc = 32'h108;
    #2 check("lw_if_ready", {31'b0, if_ready}, 32'd1);
    tick(); bus.id_ready = 1'b0; if_instr = 32'h0002_8333; if_pc = 32'h10C; #2;
    check("lw_valid", {31'b0, bus.id_valid}, 32'd1);
    check("lw_is_load", {31'b0, bus.id_is_load}, 32'd1);
    check("lw_rd", {27'b0, bus.id_rd}, 32'd5);
    check("lw_rs1_val", bus.id_rs1_val, 32'h100);
    check("lw_pc", bus.id_pc, 32'h108);
    check("luse_if_ready0", {31'b0, if_ready}, 32'd0);
    tick(); #2;
    check("luse_hold_valid", {31'b0, bus.id_valid}, 32'd1);
    check("luse_if_ready1", {31'b0, if_ready}, 32'd0);
    bus.id_ready = 1'b1;
    #2 check("luse_drain_if_ready", {31'b0, if_ready}, 32'd0);
    tick(); #2;
    check("bubble_id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("bubble_if_ready", {31'b0, if_ready}, 32'd0);
    tick(); #2;
    check("post_bubble_id_valid", {31'b0, bus.id_valid}, 32'd0);
    check("post_bubble_if_ready", {31'b0, if_ready}, 32'd1);
    tick(); if_valid = 1'b0; #2;
    check("dep_valid", {31'b0, bus.id_valid}, 32'd1);
    check("dep_pc", bus.id_pc, 32'h10C);
    check("dep_rd", {27'b0, bus.id_rd}, 32'd6);
    check("dep_rs1_val", bus.id_rs1_val, 32'h55);
    check("dep_rs2_val", bus.id_rs2_val, 32'd0);

    // 5: stall for three cycles, then flush (beats id_ready and a pending accept)
    bus.id_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0010_0393; if_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_if_ready", {31'b0, if_ready}, 32'd0);
      check("stall_valid", {31'b0, bus.id_valid}, 32'd1);
      check("stall_pc", bus.id_pc, 32'h10C);
      check("stall_rs1_val", bus.id_rs1_val, 32'h55);
      check("stall_rd", {27'b0, bus.id_rd}, 32'd6);
      tick();
    end
    flush = 1'b1; bus.id_ready = 1'b1;
    #2 check("flush_if_ready", {31'b0, if_ready}, 32'd0);
    tick(); flush = 1'b0; if_valid = 1'b0; #2;
    check("flush_id_valid", {31'b0, bus.id_valid}, 32'd0);

    // 6: BEQ x0,x0,-4 then an illegal opcode
    if_valid = 1'b1; if_instr = 32'hFE00_0EE3; if_pc = 32'h200;
    tick(); if_instr = 32'h0000_007F; if_pc = 32'h204; #2;
    check("beq_imm", bus.id_imm, 32'hFFFF_FFFC);
    check("beq_regwrite", {31'b0, bus.id_regwrite}, 32'd0);
    check("beq_rd", {27'b0, bus.id_rd}, 32'd0);
    check("beq_illegal", {31'b0, bus.id_illegal}, 32'd0);
    tick(); if_valid = 1'b0; #2;
    check("ill_valid", {31'b0, bus.id_valid}, 32'd1);
    check("ill_illegal", {31'b0, bus.id_illegal}, 32'd1);
    check("ill_regwrite", {31'b0, bus.id_regwrite}, 32'd0);
    check("ill_imm", bus.id_imm, 32'd0);
    check("ill_rd", {27'b0, bus.id_rd}, 32'd0);

    // Reset while an entry is stalled: the entry is lost
    bus.id_ready = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; #2;
    check("rst_stall_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst_stall_pc", bus.id_pc, 32'd0);
    check("rst_stall_illegal", {31'b0, bus.id_illegal}, 32'd0);
    check("rst_stall_if_ready", {31'b0, if_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
